// File: rtl/seq_det_ctrl_if.sv
// Host/serial-path bundle for the programmable pattern detector controller.
// The master side (host sequencer + serial source) drives control, config and
// the qualified bit stream; the slave side (the controller) returns status.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic [TO_W-1:0]  cfg_timeout;
  logic             din_valid;
  logic             din;
  logic             busy;
  logic             match;
  logic             done;
  logic             timeout_flag;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state;

  modport master (
    output start, abort, cfg_pattern, cfg_overlap, cfg_target, cfg_timeout,
           din_valid, din,
    input  busy, match, done, timeout_flag, match_cnt, state
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_overlap, cfg_target, cfg_timeout,
           din_valid, din,
    output busy, match, done, timeout_flag, match_cnt, state
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable serial pattern detector.
// Arms on start, latches the run config, counts PAT_W-bit pattern hits on the
// qualified stream (overlapping or not), and finishes on target or timeout.
module seq_det_ctrl #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input logic          clk,
  input logic          rst,
  seq_det_ctrl_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state_q, state_nx;

  // Shadow copy of the run config, frozen in ARM
  logic [PAT_W-1:0]  pat_q, pat_nx;
  logic              ovl_q, ovl_nx;
  logic [CNT_W-1:0]  tgt_q, tgt_nx;
  logic [TO_W-1:0]   to_q, to_nx;

  // Bit history only needs PAT_W-1 bits: the newest bit comes straight from din
  logic [PAT_W-2:0]  hist_q, hist_nx;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_q, fill_nx;
  logic [TO_W-1:0]   bitcnt_q, bitcnt_nx;

  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              tflag_q, tflag_nx;
  logic              match_q, match_nx;
  logic              done_q, done_nx;
  logic              busy_q, busy_nx;

  logic              bit_take;
  logic              hit;
  logic              tgt_hit;
  logic              to_hit;

  // Fill count saturates at PAT_W: beyond that only "window is full" matters
  function automatic logic [FILL_W-1:0] fill_sat(input logic [FILL_W-1:0] f);
    if (f >= FILL_W'(PAT_W)) return f;
    else                     return f + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  // Next-state logic and the bit-level events that drive it
  always_comb begin
    hist_n   = {hist_q, bus.din};
    bit_take = (state_q == RUN) && bus.din_valid && !bus.abort;
    hit      = bit_take && ((int'(fill_q) + 1) >= PAT_W) && (hist_n == pat_q);
    tgt_hit  = hit && ((cnt_q + 1'b1) == tgt_q);
    to_hit   = bit_take && (to_q != '0) && ((bitcnt_q + 1'b1) == to_q);
    state_nx = state_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) state_nx = ARM;
      ARM: begin
        if (bus.abort)                 state_nx = IDLE;
        else if (bus.cfg_target == '0) state_nx = DONE;
        else                           state_nx = RUN;
      end
      RUN: begin
        if (bus.abort)              state_nx = IDLE;
        else if (tgt_hit || to_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs
  always_comb begin
    pat_nx    = pat_q;
    ovl_nx    = ovl_q;
    tgt_nx    = tgt_q;
    to_nx     = to_q;
    hist_nx   = hist_q;
    fill_nx   = fill_q;
    bitcnt_nx = bitcnt_q;
    cnt_nx    = cnt_q;
    tflag_nx  = tflag_q;
    match_nx  = hit;
    done_nx   = (state_nx == DONE);
    busy_nx   = (state_nx == ARM) || (state_nx == RUN);
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cnt_nx   = '0;
          tflag_nx = 1'b0;
        end
      end
      ARM: begin
        if (!bus.abort) begin
          pat_nx    = bus.cfg_pattern;
          ovl_nx    = bus.cfg_overlap;
          tgt_nx    = bus.cfg_target;
          to_nx     = bus.cfg_timeout;
          hist_nx   = '0;
          fill_nx   = '0;
          bitcnt_nx = '0;
        end
      end
      RUN: begin
        if (bit_take) begin
          hist_nx   = hist_n[PAT_W-2:0];
          fill_nx   = (hit && !ovl_q) ? '0 : fill_sat(fill_q);
          bitcnt_nx = bitcnt_q + 1'b1;
          if (hit)               cnt_nx   = cnt_q + 1'b1;
          if (to_hit && !tgt_hit) tflag_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q    <= '0;
      ovl_q    <= 1'b0;
      tgt_q    <= '0;
      to_q     <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      tflag_q  <= 1'b0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pat_q    <= pat_nx;
      ovl_q    <= ovl_nx;
      tgt_q    <= tgt_nx;
      to_q     <= to_nx;
      hist_q   <= hist_nx;
      fill_q   <= fill_nx;
      bitcnt_q <= bitcnt_nx;
      cnt_q    <= cnt_nx;
      tflag_q  <= tflag_nx;
      match_q  <= match_nx;
      done_q   <= done_nx;
      busy_q   <= busy_nx;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.match        = match_q;
  assign bus.done         = done_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.match_cnt    = cnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed runs plus randomized traffic, compared
// every cycle against a queue-based reference of the run rules.
module tb_seq_det_ctrl;
  localparam int PAT_W = 3;
  localparam int CNT_W = 8;
  localparam int TO_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int               m_state;
  bit               m_match, m_done, m_busy, m_tflag;
  int               m_cnt;
  int               m_bits;
  bit               win[$];
  logic [PAT_W-1:0] s_pat;
  bit               s_ovl;
  int               s_tgt, s_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_match = 0; m_done = 0; m_busy = 0;
    m_tflag = 0; m_cnt = 0; m_bits = 0;
    win.delete();
  endtask

  function automatic bit window_hit();
    if (win.size() < PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++)
      if (win[win.size() - PAT_W + i] != s_pat[PAT_W-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge of the run rules, using the inputs present at the edge
  task automatic model_step();
    int nstate;
    nstate  = m_state;
    m_match = 0;
    case (m_state)
      0: if (bus.start && !bus.abort) begin
           nstate = 1; m_cnt = 0; m_tflag = 0;
         end
      1: if (bus.abort) nstate = 0;
         else begin
           s_pat = bus.cfg_pattern; s_ovl = bus.cfg_overlap;
           s_tgt = int'(bus.cfg_target); s_to = int'(bus.cfg_timeout);
           win.delete(); m_bits = 0;
           nstate = (s_tgt == 0) ? 3 : 2;
         end
      2: if (bus.abort) nstate = 0;
         else if (bus.din_valid) begin
           win.push_back(bus.din);
           if (win.size() > PAT_W) void'(win.pop_front());
           m_bits++;
           if (window_hit()) begin
             m_match = 1;
             m_cnt++;
             if (!s_ovl) win.delete();
           end
           if (m_match && m_cnt == s_tgt) nstate = 3;
           else if (s_to != 0 && m_bits == s_to) begin
             nstate = 3; m_tflag = 1;
           end
         end
      default: nstate = 0;
    endcase
    m_state = nstate;
    m_done  = (nstate == 3);
    m_busy  = (nstate == 1) || (nstate == 2);
  endtask

  task automatic check_all();
    chk("state",     32'(bus.state),        32'(m_state));
    chk("match",     32'(bus.match),        32'(m_match));
    chk("done",      32'(bus.done),         32'(m_done));
    chk("busy",      32'(bus.busy),         32'(m_busy));
    chk("tflag",     32'(bus.timeout_flag), 32'(m_tflag));
    chk("match_cnt", 32'(bus.match_cnt),    32'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.state),        0);
    chk({tag, "_match"}, 32'(bus.match),        0);
    chk({tag, "_done"},  32'(bus.done),         0);
    chk({tag, "_busy"},  32'(bus.busy),         0);
    chk({tag, "_tflag"}, 32'(bus.timeout_flag), 0);
    chk({tag, "_cnt"},   32'(bus.match_cnt),    0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    bus.start = 0; bus.abort = 0; bus.din_valid = 0; bus.din = 0;
  endtask

  task automatic scramble_cfg();
    bus.cfg_pattern = PAT_W'($urandom);
    bus.cfg_overlap = 1'($urandom);
    bus.cfg_target  = CNT_W'($urandom);
    bus.cfg_timeout = TO_W'($urandom_range(1, 3));
  endtask

  // Pulse start, step through ARM, then disturb cfg to prove it was latched
  task automatic start_run(input logic [PAT_W-1:0] pat, input bit ovl,
                           input int tgt, input int to);
    bus.cfg_pattern = pat; bus.cfg_overlap = ovl;
    bus.cfg_target = CNT_W'(tgt); bus.cfg_timeout = TO_W'(to);
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    scramble_cfg();
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.din_valid = 1; bus.din = bits[i];
      tick();
    end
    bus.din_valid = 0;
  endtask

  // Asynchronous reset between edges, checked before the next edge
  task automatic rst_pulse(input string tag);
    #2 rst = 1;
    #1 check_zero(tag);
    model_reset();
    rst = 0;
  endtask

  initial begin
    logic [6:0] t5_bits;
    rst = 1;
    set_idle();
    bus.cfg_pattern = '0; bus.cfg_overlap = 0; bus.cfg_target = '0; bus.cfg_timeout = '0;
    model_reset();
    #12 check_zero("reset");
    @(negedge clk) rst = 0;
    tick();

    // T1: non-overlapping 111, target 2
    start_run(3'b111, 0, 2, 0);
    send(32'b111111, 6);
    chk("t1_done", 32'(bus.done), 1);
    send(32'b1, 1);
    tick();
    chk("t1_cnt", 32'(bus.match_cnt), 2);
    chk("t1_tflag", 32'(bus.timeout_flag), 0);

    // T2: overlapping 111, target 5
    start_run(3'b111, 1, 5, 0);
    send(32'b111111, 6);
    chk("t2_not_done", 32'(bus.done), 0);
    send(32'b1, 1);
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_cnt", 32'(bus.match_cnt), 5);
    tick();

    // T3: timeout with no matches
    start_run(3'b101, 0, 1, 4);
    send(32'b1111, 4);
    chk("t3_done", 32'(bus.done), 1);
    chk("t3_tflag", 32'(bus.timeout_flag), 1);
    chk("t3_cnt", 32'(bus.match_cnt), 0);
    tick();
    chk("t3_tflag_sticky", 32'(bus.timeout_flag), 1);

    // T4: target and timeout on the same bit
    start_run(3'b111, 0, 1, 3);
    send(32'b111, 3);
    chk("t4_match", 32'(bus.match), 1);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_tflag", 32'(bus.timeout_flag), 0);
    tick();

    // T5: gapped valid stream with junk, then abort
    start_run(3'b110, 0, 3, 0);
    t5_bits = 7'b1101101;
    for (int i = 6; i >= 0; i--) begin
      bus.din_valid = 1; bus.din = t5_bits[i];
      tick();
      bus.din_valid = 0; bus.din = 1'($urandom);
      tick();
    end
    chk("t5_cnt_pre", 32'(bus.match_cnt), 2);
    bus.abort = 1; bus.din_valid = 1; bus.din = 0;
    tick();
    bus.abort = 0; bus.din_valid = 0;
    chk("t5_state", 32'(bus.state), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_cnt", 32'(bus.match_cnt), 2);
    tick();

    // T6: async reset mid-run, then a zero-target run
    start_run(3'b111, 1, 9, 0);
    send(32'b1111, 4);
    rst_pulse("t6_rst");
    bus.cfg_target = '0;
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    chk("t6_done", 32'(bus.done), 1);
    chk("t6_cnt", 32'(bus.match_cnt), 0);
    tick();

    // Randomized traffic: starts, aborts, gaps and config churn
    for (int i = 0; i < 3000; i++) begin
      bus.start     = ($urandom % 8) == 0;
      bus.abort     = ($urandom % 60) == 0;
      bus.din_valid = ($urandom % 4) != 0;
      bus.din       = 1'($urandom);
      bus.cfg_pattern = PAT_W'($urandom);
      bus.cfg_overlap = 1'($urandom);
      bus.cfg_target  = CNT_W'($urandom % 5);
      bus.cfg_timeout = (($urandom % 3) == 0) ? '0 : TO_W'($urandom_range(2, 16));
      tick();
      if ((i % 700) == 350) rst_pulse("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
